// File: rtl/multicycle_control_fsm.sv
// Moore controller that sequences one MIPS instruction over 3-5 cycles, with a memory
// ready/request handshake, stall timeout and illegal-opcode trap. Define MIPS_BNE_EN to add bne.
module multicycle_control_fsm #(
    parameter int               OPW      = 6,
    parameter logic [OPW-1:0]   OP_RTYPE = 6'b000000,
    parameter logic [OPW-1:0]   OP_LW    = 6'b100011,
    parameter logic [OPW-1:0]   OP_SW    = 6'b101011,
    parameter logic [OPW-1:0]   OP_BEQ   = 6'b000100,
    parameter logic [OPW-1:0]   OP_ADDI  = 6'b001000,
    parameter logic [OPW-1:0]   OP_J     = 6'b000010,
    parameter logic [OPW-1:0]   OP_BNE   = 6'b000101,
    parameter int               TIMEOUT  = 16,
    parameter int               TW       = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] Opcode,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           IorD,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           PCWrite,
    output logic           Branch,
    output logic           BranchNe,
    output logic [1:0]     PCSrc,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ALUOp,
    output logic           RegWrite,
    output logic           MemtoReg,
    output logic           RegDst,
    output logic [3:0]     state,
    output logic           err,
    output logic [1:0]     err_cause
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BEQ     = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;
    localparam logic [3:0] S_ERR     = 4'd12;
`ifdef MIPS_BNE_EN
    localparam logic [3:0] S_BNE     = 4'd13;
`endif

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // With TIMEOUT=0 the limit value is meaningless; the trap is masked below.
    localparam logic [TW-1:0] WAIT_LIMIT = TW'(TIMEOUT - 1);

    logic [3:0]    next_state;
    logic [1:0]    trap_cause;
    logic [TW-1:0] wait_cnt;
    logic          waiting;
    logic          timed_out;

    assign waiting   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timed_out = (TIMEOUT != 0) && waiting && !mem_ready && (wait_cnt == WAIT_LIMIT);

    always_comb begin
        next_state = state;
        trap_cause = 2'b00;
        case (state)
            S_FETCH:   if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                if (Opcode == OP_LW || Opcode == OP_SW) next_state = S_MEMADR;
                else if (Opcode == OP_RTYPE)            next_state = S_EXECUTE;
                else if (Opcode == OP_BEQ)              next_state = S_BEQ;
                else if (Opcode == OP_ADDI)             next_state = S_ADDIEX;
                else if (Opcode == OP_J)                next_state = S_JUMP;
`ifdef MIPS_BNE_EN
                else if (Opcode == OP_BNE)              next_state = S_BNE;
`else
                else if (Opcode == OP_BNE) begin
                    next_state = S_ERR;
                    trap_cause = CAUSE_ILLEGAL;
                end
`endif
                else begin
                    next_state = S_ERR;
                    trap_cause = CAUSE_ILLEGAL;
                end
            end
            S_MEMADR:  next_state = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) next_state = S_MEMWB;
            S_MEMWB:   next_state = S_FETCH;
            S_MEMWR:   if (mem_ready) next_state = S_FETCH;
            S_EXECUTE: next_state = S_ALUWB;
            S_ALUWB:   next_state = S_FETCH;
            S_BEQ:     next_state = S_FETCH;
            S_ADDIEX:  next_state = S_ADDIWB;
            S_ADDIWB:  next_state = S_FETCH;
            S_JUMP:    next_state = S_FETCH;
`ifdef MIPS_BNE_EN
            S_BNE:     next_state = S_FETCH;
`endif
            S_ERR:     next_state = S_ERR;
            default:   next_state = S_FETCH;
        endcase
        // A stalled access that reaches the limit overrides the normal successor.
        if (timed_out) begin
            next_state = S_ERR;
            trap_cause = CAUSE_TIMEOUT;
        end
    end

    // Only the wait states self-loop, so any state change is an entry that restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            err       <= 1'b0;
            err_cause <= 2'b00;
        end else begin
            state <= next_state;
            if (next_state != state)
                wait_cnt <= '0;
            else if (waiting && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            if (next_state == S_ERR && state != S_ERR) begin
                err       <= 1'b1;
                err_cause <= trap_cause;
            end
        end
    end

    always_comb begin
        mem_req  = 1'b0;
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        BranchNe = 1'b0;
        PCSrc    = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        RegWrite = 1'b0;
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE:  ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                Branch  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB:  RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
`ifdef MIPS_BNE_EN
            S_BNE: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSrc    = 2'b01;
                BranchNe = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multicycle successor to the single-cycle main decoder.
- Moore state machine that sequences one MIPS instruction over 3–5 cycles, driving datapath strobes cycle by cycle.
- Adds a memory ready/request handshake with a stall timeout, illegal-opcode trapping, and parametrised opcode encodings.
- Sits between the instruction register's opcode field and the shared multicycle datapath and memory port.

Parameters:
OPW, 6, opcode field width
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word
OP_SW, 6'b101011, store word
OP_BEQ, 6'b000100, branch equal
OP_ADDI, 6'b001000, add immediate
OP_J, 6'b000010, jump
OP_BNE, 6'b000101, branch not equal (used only with optional feature)
TIMEOUT, 16, max cycles waiting on mem_ready; 0 disables the timeout
TW, 5, timeout counter width; must satisfy 2^TW > TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  reset
Opcode  in  OPW  instruction opcode from IR
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
IorD  out  1  address mux: 0=PC, 1=ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
PCWrite  out  1  unconditional PC load
Branch  out  1  conditional PC load on Zero
BranchNe  out  1  conditional PC load on !Zero
PCSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
ALUSrcA  out  1  0=PC, 1=A register
ALUSrcB  out  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
ALUOp  out  2  same encoding as the ALU decoder (00 add, 01 sub, 10 funct)
RegWrite  out  1  register file write
MemtoReg  out  1  write-back source: 1=data register
RegDst  out  1  1=rd, 0=rt
state  out  4  current state encoding (debug)
err  out  1  sticky trap flag
err_cause  out  2  01=illegal opcode, 10=memory timeout

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- On rst: state=FETCH(0), timeout counter=0, err=0, err_cause=00.
- Rst mid-instruction abandons the instruction; any pending mem_req drops the next cycle.
- Outputs not listed for a state are 0. All outputs are decoded from state only, except IRWrite/PCWrite in FETCH, which are gated by mem_ready.

States, outputs and transitions:
- 0 FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite=PCWrite=mem_ready. Stay until mem_ready, then DECODE.
- 1 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Opcode:
  - lw/sw -> MEMADR
  - R-type -> EXECUTE
  - beq -> BEQ
  - addi -> ADDIEX
  - j -> JUMP
  - anything else -> ERR with cause 01
- 2 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD; sw -> MEMWR.
- 3 MEMRD: mem_req=1, IorD=1. On mem_ready -> MEMWB.
- 4 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- 5 MEMWR: mem_req=1, IorD=1, MemWrite=1. On mem_ready -> FETCH.
- 6 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
- 7 ALUWB: RegWrite=1, RegDst=1 -> FETCH.
- 8 BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 -> FETCH.
- 9 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
- 10 ADDIWB: RegWrite=1 -> FETCH.
- 11 JUMP: PCSrc=10, PCWrite=1 -> FETCH.
- 12 ERR: all strobes and mem_req=0, err=1. Held until rst.

Timeout and latency:
- Timeout counter clears on entry to FETCH, MEMRD or MEMWR, and increments each wait cycle with mem_ready=0.
- If the counter equals TIMEOUT-1 and mem_ready=0 -> ERR with cause 10.
- mem_ready in the same cycle as the limit wins: normal transition, no trap.
- Latency with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.

Optional Feature:
- MIPS_BNE_EN defined:
  - DECODE maps OP_BNE to state 13 BNE.
  - BNE outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, BranchNe=1, then -> FETCH.
- MIPS_BNE_EN undefined:
  - BranchNe is tied to 0 and state 13 does not exist.
  - OP_BNE traps to ERR with cause 01.

Test Plan:
- rst high 2 cycles, then Opcode=000000 with mem_ready=1 -> states 0,1,6,7,0. RegWrite=1 and RegDst=1 only in state 7; IRWrite=PCWrite=1 in cycle 0.
- lw (100011), mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles with IorD=1, mem_req=1; then MEMWB asserts RegWrite=1, MemtoReg=1; total 8 cycles.
- sw (101011), mem_ready=1 -> MEMWR asserts MemWrite=1 for exactly 1 cycle; RegWrite never asserted.
- beq then j -> BEQ asserts Branch=1, PCSrc=01, ALUOp=01; JUMP asserts PCWrite=1, PCSrc=10; each takes 3 cycles.
- Opcode=111111 -> ERR after DECODE with err=1, err_cause=01. Outputs stay 0 for 10 cycles; rst returns to FETCH with err=0.
- TIMEOUT=16, mem_ready held 0 in FETCH -> ERR with cause 10 after exactly 16 FETCH cycles. Repeat with mem_ready=1 on the 16th cycle -> DECODE, no trap.
